// File: rtl/motor_pkg.sv
// Shared motor-control definitions: status encodings, duty levels, bridge pin patterns.
package motor_pkg;

  // Sequencer status, also shown on the 7-segment display.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Duty levels expressed on the default PWM period.
  localparam int unsigned PWM_PERIOD_DEF = 2500;
  localparam int unsigned DUTY_100       = 2500;
  localparam int unsigned DUTY_75        = 1875;
  localparam int unsigned DUTY_50        = 1250;
  localparam int unsigned DUTY_25        = 625;

  // L298 input pin patterns; motor B is wired mirrored to motor A.
  localparam logic [1:0] BRIDGE_COAST = 2'b00;
  localparam logic [1:0] BRIDGE_A_FWD = 2'b10;
  localparam logic [1:0] BRIDGE_A_REV = 2'b01;
  localparam logic [1:0] BRIDGE_B_FWD = 2'b01;
  localparam logic [1:0] BRIDGE_B_REV = 2'b10;

  // Duty for a switch level (0=100%,1=75%,2=50%,3=25%) rescaled to the given period.
  function automatic int unsigned duty_of(input int unsigned period, input logic [1:0] level);
    int unsigned base;
    case (level)
      2'd0:    base = DUTY_100;
      2'd1:    base = DUTY_75;
      2'd2:    base = DUTY_50;
      default: base = DUTY_25;
    endcase
    return (period * base) / PWM_PERIOD_DEF;
  endfunction

endpackage

// File: rtl/oc_filter.sv
// Overcurrent filter for one motor channel: sync, consecutive-high counter, trip flag.
module oc_filter #(
  parameter int unsigned OC_LIMIT = 2499
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sense_i,
  output logic sense_s_o,
  output logic trip_o
);

  localparam int unsigned CNT_W = $clog2(OC_LIMIT + 1);

  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             trip_q;

  // Count consecutive synced-high cycles, saturating at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!s2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(OC_LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchronizer, counter and trip flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      trip_q <= 1'b0;
    end else begin
      s1_q   <= sense_i;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      trip_q <= (cnt_d == CNT_W'(OC_LIMIT));
    end
  end

  assign sense_s_o = s2_q;
  assign trip_o    = trip_q;

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Motor command sequencer: slew-limited duty, dead-time reversal, latched overcurrent fault.
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int unsigned PW_W       = 12,
  parameter int unsigned PWM_PERIOD = 2500,
  parameter int unsigned RAMP_DIV   = 10000,
  parameter int unsigned RAMP_STEP  = 25,
  parameter int unsigned DEAD_CYC   = 1000000,
  parameter int unsigned OC_LIMIT   = 2499
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      sw,
  input  logic            fault_clr,
  input  logic            cur_sense_a,
  input  logic            cur_sense_b,
  output logic [PW_W-1:0] pulse_width,
  output logic [1:0]      bridge_a,
  output logic [1:0]      bridge_b,
  output logic            dir_fwd,
  output logic            fault,
  output logic [1:0]      state_o
);

  localparam int unsigned DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [PW_W-1:0] STEP = PW_W'(RAMP_STEP);

  logic [7:0]        sw_s1_q, sw_s2_q;
  logic              clr_s1_q, clr_s2_q, clr_prev_q;
  logic [DIV_W-1:0]  div_q;
  logic [DEAD_W-1:0] dead_q;
  state_e            state_q;
  logic [PW_W-1:0]   pw_q;
  logic              dir_q;
  logic [1:0]        ba_q, bb_q;
  logic              fault_q;

  logic              sense_a_s, sense_b_s, trip_a, trip_b;
  logic              trip_c, tick_c, clr_rise_c, tgt_fwd_c;
  logic [PW_W-1:0]   tgt_c, eff_c, pw_d;

  oc_filter #(.OC_LIMIT(OC_LIMIT)) u_oc_a (
    .clk(clk), .rst_n(rst_n), .sense_i(cur_sense_a), .sense_s_o(sense_a_s), .trip_o(trip_a)
  );

  oc_filter #(.OC_LIMIT(OC_LIMIT)) u_oc_b (
    .clk(clk), .rst_n(rst_n), .sense_i(cur_sense_b), .sense_s_o(sense_b_s), .trip_o(trip_b)
  );

  assign trip_c     = trip_a | trip_b;
  assign tick_c     = (div_q == DIV_W'(RAMP_DIV - 1));
  assign clr_rise_c = clr_s2_q & ~clr_prev_q;

  // Input synchronizers, clear edge history and free-running slew divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      clr_s1_q   <= 1'b0;
      clr_s2_q   <= 1'b0;
      clr_prev_q <= 1'b0;
      div_q      <= '0;
    end else begin
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      clr_s1_q   <= fault_clr;
      clr_s2_q   <= clr_s1_q;
      clr_prev_q <= clr_s2_q;
      div_q      <= tick_c ? '0 : div_q + DIV_W'(1);
    end
  end

  // Target decode: highest set switch wins; no switch holds the current direction at zero.
  always_comb begin
    tgt_c     = '0;
    tgt_fwd_c = dir_q;
    for (int i = 0; i < 8; i++) begin
      if (sw_s2_q[i]) begin
        tgt_c     = PW_W'(duty_of(PWM_PERIOD, 2'(i)));
        tgt_fwd_c = (i < 4);
      end
    end
  end

  // Slew one step toward the effective target, clamping without wrap.
  always_comb begin
    eff_c = (tgt_fwd_c == dir_q) ? tgt_c : '0;
    pw_d  = pw_q;
    if (pw_q < eff_c) begin
      pw_d = ((eff_c - pw_q) > STEP) ? pw_q + STEP : eff_c;
    end else if (pw_q > eff_c) begin
      pw_d = ((pw_q - eff_c) > STEP) ? pw_q - STEP : eff_c;
    end
  end

  // Main sequencer FSM with registered outputs; overcurrent trip overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pw_q    <= '0;
      dir_q   <= 1'b1;
      ba_q    <= BRIDGE_A_FWD;
      bb_q    <= BRIDGE_B_FWD;
      fault_q <= 1'b0;
      dead_q  <= '0;
    end else if (trip_c) begin
      state_q <= ST_FAULT;
      fault_q <= 1'b1;
      pw_q    <= '0;
      ba_q    <= BRIDGE_COAST;
      bb_q    <= BRIDGE_COAST;
      dead_q  <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (pw_q == '0 && tgt_fwd_c != dir_q) begin
            state_q <= ST_DEAD;
            ba_q    <= BRIDGE_COAST;
            bb_q    <= BRIDGE_COAST;
            dead_q  <= '0;
          end else if (tick_c) begin
            pw_q <= pw_d;
          end
        end
        ST_DEAD: begin
          if (dead_q == DEAD_W'(DEAD_CYC - 1)) begin
            state_q <= ST_RUN;
            dir_q   <= ~dir_q;
            ba_q    <= dir_q ? BRIDGE_A_REV : BRIDGE_A_FWD;
            bb_q    <= dir_q ? BRIDGE_B_REV : BRIDGE_B_FWD;
            dead_q  <= '0;
          end else begin
            dead_q <= dead_q + DEAD_W'(1);
          end
        end
        ST_FAULT: begin
          if (clr_rise_c && !sense_a_s && !sense_b_s) begin
            state_q <= ST_RUN;
            fault_q <= 1'b0;
            pw_q    <= '0;
            ba_q    <= dir_q ? BRIDGE_A_FWD : BRIDGE_A_REV;
            bb_q    <= dir_q ? BRIDGE_B_FWD : BRIDGE_B_REV;
          end
        end
        default: begin
          state_q <= ST_FAULT;
          fault_q <= 1'b1;
          pw_q    <= '0;
          ba_q    <= BRIDGE_COAST;
          bb_q    <= BRIDGE_COAST;
        end
      endcase
    end
  end

  assign pulse_width = pw_q;
  assign bridge_a    = ba_q;
  assign bridge_b    = bb_q;
  assign dir_fwd     = dir_q;
  assign fault       = fault_q;
  assign state_o     = state_q;

endmodule
